// File: rtl/pdm_capture_scheduler_if.sv
// Handshake and sample bus between the PDM capture scheduler and its environment.
interface pdm_capture_scheduler_if #(
    parameter int unsigned AMP_W = 7
);
    logic             start;
    logic             abort;
    logic             mic_en;
    logic [AMP_W-1:0] amp_in;
    logic             amp_valid;
    logic [AMP_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             overflow;

    modport master (
        output start, abort, amp_in, amp_valid, out_ready,
        input  mic_en, out_data, out_valid, busy, done, overflow
    );

    modport slave (
        input  start, abort, amp_in, amp_valid, out_ready,
        output mic_en, out_data, out_valid, busy, done, overflow
    );
endinterface

// File: rtl/pdm_capture_scheduler.sv
// PDM capture scheduler: mic warm-up discard, fixed-length capture into a small
// output FIFO, drain, and abort handling. Every output comes straight from a flop.
module pdm_capture_scheduler #(
    parameter int unsigned WARMUP_SAMPLES = 16,
    parameter int unsigned CAPTURE_LEN    = 1024,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned AMP_W          = 7
) (
    input  logic                         clk_in,
    input  logic                         rst_n,
    pdm_capture_scheduler_if.slave       bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = 16;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WARMUP  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             mic_en_q, mic_en_d;
    logic             out_valid_q, out_valid_d;
    logic [AMP_W-1:0] out_data_q, out_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic             full_c, empty_c, pop_c, push_c, flush_c, abort_c;
    logic [AMP_W-1:0] mem [FIFO_DEPTH];

    assign full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign abort_c = bus.abort && (state_q != S_IDLE);
    assign pop_c   = out_valid_q && bus.out_ready && !abort_c;
    assign cnt_inc = cnt_q + CW'(1);

    // Next-state, counter, flag and FIFO-control decode; abort overrides everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mic_en_d   = mic_en_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;
        push_c     = 1'b0;
        flush_c    = 1'b0;
        if (abort_c) begin
            state_d  = S_IDLE;
            mic_en_d = 1'b0;
            cnt_d    = '0;
            flush_c  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        overflow_d = 1'b0;
                        cnt_d      = '0;
                        mic_en_d   = 1'b1;
                        state_d    = (WARMUP_SAMPLES == 0) ? S_CAPTURE : S_WARMUP;
                    end
                end
                S_WARMUP: begin
                    if (bus.amp_valid) begin
                        if (cnt_inc == CW'(WARMUP_SAMPLES)) begin
                            cnt_d   = '0;
                            state_d = S_CAPTURE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (bus.amp_valid) begin
                        if (!full_c || pop_c) begin
                            push_c = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                        cnt_d = cnt_inc;
                        if (cnt_inc == CW'(CAPTURE_LEN)) begin
                            state_d  = S_DRAIN;
                            mic_en_d = 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (empty_c) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Pointer update and look-ahead of the FIFO head so OUT_DATA/OUT_VALID can be flops.
    always_comb begin
        wr_ptr_d = flush_c ? '0 : wr_ptr_q + PW'(push_c);
        rd_ptr_d = flush_c ? '0 : rd_ptr_q + PW'(pop_c);
        out_valid_d = (rd_ptr_d != wr_ptr_d);
        if (rd_ptr_d == wr_ptr_d) begin
            out_data_d = '0;
        end else if (push_c && (rd_ptr_d == wr_ptr_q)) begin
            out_data_d = bus.amp_in;
        end else begin
            out_data_d = mem[rd_ptr_d[AW-1:0]];
        end
        busy_d = (state_d != S_IDLE);
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk_in) begin
        if (push_c) begin
            mem[wr_ptr_q[AW-1:0]] <= bus.amp_in;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mic_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mic_en_q    <= mic_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.mic_en    = mic_en_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/pdm_capture_scheduler.md
PDM_CAPTURE_SCHEDULER -- requirements
Module: pdm_capture_scheduler

Interface
REQ-001 Parameter WARMUP_SAMPLES, default 16: number of amplitude samples discarded after the microphone is enabled.
REQ-002 Parameter CAPTURE_LEN, default 1024: number of amplitude samples counted per capture run (range 1..65535).
REQ-003 Parameter FIFO_DEPTH, default 4: output buffer depth in entries, power of two, 2 or greater.
REQ-004 Parameter AMP_W, default 7: amplitude sample width in bits.
REQ-005 CLK_IN  in  1  system clock; all logic is on the rising edge.
REQ-006 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-007 START  in  1  one-cycle capture request.
REQ-008 ABORT  in  1  one-cycle cancel request.
REQ-009 MIC_EN  out  1  enables the PDM front-end clock and decimator.
REQ-010 AMP_IN  in  AMP_W  amplitude sample from the PDM front-end.
REQ-011 AMP_VALID  in  1  one-cycle strobe qualifying AMP_IN.
REQ-012 OUT_DATA  out  AMP_W  buffered sample at the FIFO head.
REQ-013 OUT_VALID  out  1  OUT_DATA is valid.
REQ-014 OUT_READY  in  1  consumer accepts OUT_DATA.
REQ-015 BUSY  out  1  high in every state except IDLE.
REQ-016 DONE  out  1  one-cycle pulse when a run completes normally.
REQ-017 OVERFLOW  out  1  sticky flag: a sample was dropped because the FIFO was full.

Function
REQ-018 The FSM SHALL have four states: IDLE, WARMUP, CAPTURE, DRAIN. All outputs SHALL be registered.
REQ-019 In IDLE, START SHALL clear OVERFLOW and the sample counter and enter WARMUP, or CAPTURE if WARMUP_SAMPLES = 0. MIC_EN SHALL go to 1 on the same edge.
REQ-020 START SHALL be ignored outside IDLE.
REQ-021 In WARMUP, each AMP_VALID SHALL increment the counter and discard AMP_IN.
REQ-022 On the WARMUP_SAMPLES-th valid, the block SHALL clear the counter and enter CAPTURE. That sample SHALL be discarded.
REQ-023 In CAPTURE, each AMP_VALID SHALL push AMP_IN into the FIFO and increment the counter.
REQ-024 If the FIFO is full and no pop occurs in that cycle, the sample SHALL be dropped, OVERFLOW SHALL be set, and the sample SHALL still count toward CAPTURE_LEN.
REQ-025 A push and a pop in the same cycle while the FIFO is full SHALL both succeed, with no overflow.
REQ-026 On the CAPTURE_LEN-th valid, the block SHALL push that sample (subject to REQ-024), enter DRAIN, and set MIC_EN to 0 on the same edge.
REQ-027 In DRAIN, AMP_VALID SHALL be ignored. When the FIFO is empty, the block SHALL enter IDLE and pulse DONE for exactly one cycle.
REQ-028 ABORT in any non-IDLE state SHALL, on the next edge: enter IDLE, flush the FIFO, set MIC_EN to 0, clear the counter, and keep OVERFLOW. DONE SHALL NOT assert.
REQ-029 ABORT SHALL take priority over START, AMP_VALID and OUT_READY in the same cycle. ABORT in IDLE SHALL have no effect.
REQ-030 OUT_VALID SHALL equal FIFO not-empty. A pop SHALL occur when OUT_VALID and OUT_READY are both 1.
REQ-031 Latency: a sample pushed into an empty FIFO on edge n SHALL appear on OUT_DATA/OUT_VALID after edge n.
REQ-032 OUT_DATA SHALL remain stable while OUT_VALID = 1 and OUT_READY = 0.
REQ-033 FIFO order SHALL be first-in first-out. Read and write pointers SHALL be log2(FIFO_DEPTH)+1 bits, with wrap-around and no lost entries.
REQ-034 The sample counter SHALL be 16 bits and SHALL never exceed CAPTURE_LEN.

Reset
REQ-035 While RST_N = 0, the block SHALL be in IDLE with all of the following at 0: MIC_EN, OUT_VALID, OUT_DATA, BUSY, DONE, OVERFLOW, FIFO pointers and counter.
REQ-036 Reset mid-run SHALL discard FIFO contents. The first edge after release SHALL see IDLE.

Verification (WARMUP_SAMPLES=2, CAPTURE_LEN=4, FIFO_DEPTH=4, AMP_W=7)
REQ-037 Nominal run: START; AMP_IN 10,11,20,21,22,23 on AMP_VALID; OUT_READY=1 -> 10 and 11 discarded; OUT_DATA sequence 20,21,22,23; MIC_EN falls with the 23 push; DONE pulses once; OVERFLOW=0.
REQ-038 Backpressure: OUT_READY=0 throughout capture with 4 samples -> FIFO full, OVERFLOW=0, state DRAIN; raising OUT_READY drains 4 words, then DONE.
REQ-039 Overflow: FIFO_DEPTH=2, OUT_READY=0, 4 capture samples 1,2,3,4 -> OVERFLOW=1, FIFO holds 1,2, counter reaches 4, DRAIN entered; after the drain, DONE pulses.
REQ-040 Full push plus pop: FIFO full, OUT_READY=1 and AMP_VALID in the same cycle -> no overflow, occupancy unchanged, order preserved.
REQ-041 ABORT during CAPTURE with 2 words buffered -> next cycle IDLE, OUT_VALID=0, MIC_EN=0, no DONE; a following START runs normally.
REQ-042 RST_N low mid-DRAIN with 3 words buffered -> all outputs 0 immediately; START issued while not IDLE is ignored.
